// File: rtl/ddr_tx_serializer_pkg.sv
// Shared types and width helpers for the DDR transmit serializer.
// Widths derive from the instance parameters through constant functions.
package ddr_tx_serializer_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    function automatic int pairs_of(input int data_width);
        return data_width / 2;
    endfunction

    function automatic int pair_cnt_w(input int data_width);
        return $clog2(data_width / 2);
    endfunction

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Pointers are log2(DEPTH) bits and wrap on their own.
module sync_fifo
    import ddr_tx_serializer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CW = fifo_cnt_w(DEPTH),
    localparam int PW = fifo_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_tx_serializer.sv
// Word-to-DDR serializer feeding ODDR2 D0/D1; two bits per clock.
// Words stream back to back; outputs park at IDLE_LEVEL between frames.
module ddr_tx_serializer
    import ddr_tx_serializer_pkg::*;
#(
    parameter int   DATA_WIDTH = 16,
    parameter int   FIFO_DEPTH = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  d0,
    output logic                  d1,
    output logic                  ce,
    output logic                  oe,
    output logic                  frame_start,
    output logic                  frame_done
);

    localparam int PAIRS = pairs_of(DATA_WIDTH);
    localparam int PCW   = pair_cnt_w(DATA_WIDTH);
    localparam int FCW   = fifo_cnt_w(FIFO_DEPTH);
    localparam int I0    = MSB_FIRST ? DATA_WIDTH - 1 : 0;
    localparam int I1    = MSB_FIRST ? DATA_WIDTH - 2 : 1;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [PCW-1:0]        pair_cnt;
    logic [FCW-1:0]        fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  load;
    logic                  shift_en;
    logic                  last_pair;
    logic                  run_q;

    assign push      = din_valid && din_ready;
    assign last_pair = (pair_cnt == PCW'(PAIRS - 1));

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (din),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // run_q holds ready and ce low through reset and releases both together
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign ce        = run_q;
    assign din_ready = run_q && !fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        shift_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_pair) begin
                    shift_en = 1'b1;
                end else if (!fifo_empty) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh       <= '0;
            pair_cnt <= '0;
        end else if (load) begin
            sh       <= fifo_rdata;
            pair_cnt <= '0;
        end else if (shift_en) begin
            if (MSB_FIRST) begin
                sh <= {sh[DATA_WIDTH-3:0], 2'b00};
            end else begin
                sh <= {2'b00, sh[DATA_WIDTH-1:2]};
            end
            pair_cnt <= pair_cnt + 1'b1;
        end
    end

    assign oe          = (state == SHIFT);
    assign d0          = oe ? sh[I0] : IDLE_LEVEL;
    assign d1          = oe ? sh[I1] : IDLE_LEVEL;
    assign frame_start = oe && (pair_cnt == '0);
    assign frame_done  = oe && last_pair;

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Directed bench for ddr_tx_serializer: an MSB-first and an LSB-first
// instance share clock and reset; expectations are hand-computed.
module tb_ddr_tx_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        d0, d1, ce, oe, frame_start, frame_done;

    logic [15:0] din_l;
    logic        din_valid_l;
    logic        din_ready_l;
    logic        d0_l, d1_l, ce_l, oe_l, fs_l, fd_l;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] words [10];
    int          acc_cyc [10];
    int          fs_cyc [16];
    logic [15:0] rx [16];
    logic        rdy_hist [100];
    int          n_fs, n_rx, oe_cnt, first_oe, last_oe;

    always #5 clk = ~clk;

    ddr_tx_serializer #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (4),
        .MSB_FIRST  (1'b1),
        .IDLE_LEVEL (1'b0)
    ) u_msb (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .d0          (d0),
        .d1          (d1),
        .ce          (ce),
        .oe          (oe),
        .frame_start (frame_start),
        .frame_done  (frame_done)
    );

    ddr_tx_serializer #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (4),
        .MSB_FIRST  (1'b0),
        .IDLE_LEVEL (1'b0)
    ) u_lsb (
        .clk         (clk),
        .reset       (reset),
        .din         (din_l),
        .din_valid   (din_valid_l),
        .din_ready   (din_ready_l),
        .d0          (d0_l),
        .d1          (d1_l),
        .ce          (ce_l),
        .oe          (oe_l),
        .frame_start (fs_l),
        .frame_done  (fd_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives words with din_valid held high until each is taken, and
    // records acceptance edges, output pulses and the rebuilt words.
    task automatic run_stream(input int nw, input int ncyc);
        int          idx;
        bit          took;
        logic [15:0] w;
        idx = 0;
        w = '0;
        n_fs = 0;
        n_rx = 0;
        oe_cnt = 0;
        first_oe = -1;
        last_oe = -1;
        for (int i = 0; i < 16; i++) begin
            rx[i] = '0;
            fs_cyc[i] = -1;
        end
        for (int i = 0; i < 10; i++) acc_cyc[i] = -1;
        for (int c = 0; c < ncyc; c++) begin
            if (idx < nw) begin
                din_valid = 1'b1;
                din = words[idx];
            end else begin
                din_valid = 1'b0;
            end
            took = din_valid && din_ready;
            tick();
            if (took) begin
                acc_cyc[idx] = c;
                idx++;
            end
            rdy_hist[c] = din_ready;
            if (oe) begin
                oe_cnt++;
                if (first_oe < 0) first_oe = c;
                last_oe = c;
                w = {w[13:0], d0, d1};
            end
            if (frame_start && n_fs < 16) begin
                fs_cyc[n_fs] = c;
                n_fs++;
            end
            if (frame_done && n_rx < 16) begin
                rx[n_rx] = w;
                n_rx++;
            end
        end
        din_valid = 1'b0;
    endtask

    logic [1:0] exp_pairs [8];
    int         oe_seen;

    initial begin
        reset = 1'b1;
        din_valid = 1'b1;
        din = 16'hFFFF;
        din_valid_l = 1'b0;
        din_l = '0;

        // reset held 3 cycles with din_valid high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_d0d1", 32'({d0, d1}), 32'd0);
            check("rst_oe", 32'(oe), 32'd0);
            check("rst_ce", 32'(ce), 32'd0);
            check("rst_ready", 32'(din_ready), 32'd0);
            check("rst_pulses", 32'({frame_start, frame_done}), 32'd0);
        end
        reset = 1'b0;
        din_valid = 1'b0;
        tick();
        check("rel_ce", 32'(ce), 32'd1);
        check("rel_ready", 32'(din_ready), 32'd1);
        check("rel_oe", 32'(oe), 32'd0);

        // single word A5C3, MSB first
        exp_pairs = '{2'b10, 2'b10, 2'b01, 2'b01,
                      2'b11, 2'b00, 2'b00, 2'b11};
        din = 16'hA5C3;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        check("one_accept_oe", 32'(oe), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("one_pair", 32'({d0, d1}), 32'(exp_pairs[i]));
            check("one_oe", 32'(oe), 32'd1);
            check("one_fs", 32'(frame_start), 32'(i == 0));
            check("one_fd", 32'(frame_done), 32'(i == 7));
            tick();
        end
        check("one_idle_oe", 32'(oe), 32'd0);
        check("one_idle_d", 32'({d0, d1}), 32'd0);
        tick();

        // four words back to back
        words[0] = 16'h1234;
        words[1] = 16'hFFFF;
        words[2] = 16'h0000;
        words[3] = 16'h8001;
        run_stream(4, 40);
        check("str_oe_cnt", 32'(oe_cnt), 32'd32);
        check("str_first_oe", 32'(first_oe), 32'd1);
        check("str_last_oe", 32'(last_oe), 32'd32);
        check("str_n_fs", 32'(n_fs), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("str_fs_cyc", 32'(fs_cyc[i]), 32'(1 + 8 * i));
            check("str_word", 32'(rx[i]), 32'(words[i]));
        end
        check("str_n_rx", 32'(n_rx), 32'd4);

        // ten words with din_valid held high
        for (int i = 0; i < 10; i++) begin
            words[i] = 16'(16'h1111 * (i + 1) ^ 16'h5A00);
        end
        run_stream(10, 90);
        check("bp_rdy3", 32'(rdy_hist[3]), 32'd1);
        check("bp_rdy4", 32'(rdy_hist[4]), 32'd0);
        check("bp_acc4", 32'(acc_cyc[4]), 32'd4);
        check("bp_acc5", 32'(acc_cyc[5]), 32'd10);
        for (int i = 6; i < 10; i++) begin
            check("bp_pace", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd8);
        end
        check("bp_oe_cnt", 32'(oe_cnt), 32'd80);
        check("bp_oe_span", 32'(last_oe - first_oe + 1), 32'd80);
        check("bp_n_rx", 32'(n_rx), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check("bp_word", 32'(rx[i]), 32'(words[i]));
        end
        tick();

        // reset during pair 3 with two words queued
        din_valid = 1'b1;
        din = 16'hF00F;
        tick();
        din = 16'hAAAA;
        tick();
        din = 16'h5555;
        tick();
        din_valid = 1'b0;
        tick();
        check("mid_oe", 32'(oe), 32'd1);
        check("mid_pair3", 32'({d0, d1}), 32'b00);
        reset = 1'b1;
        check("mid_fd_pre", 32'(frame_done), 32'd0);
        tick();
        check("mid_rst_d", 32'({d0, d1}), 32'd0);
        check("mid_rst_oe", 32'(oe), 32'd0);
        check("mid_rst_fd", 32'(frame_done), 32'd0);
        reset = 1'b0;
        tick();
        check("mid_rel_ready", 32'(din_ready), 32'd1);
        oe_seen = 0;
        for (int i = 0; i < 20; i++) begin
            oe_seen += int'(oe) + int'(frame_done);
            tick();
        end
        check("mid_flushed", 32'(oe_seen), 32'd0);

        // LSB-first instance, 0001
        din_l = 16'h0001;
        din_valid_l = 1'b1;
        tick();
        din_valid_l = 1'b0;
        tick();
        check("lsb_first_pair", 32'({d0_l, d1_l}), 32'b10);
        check("lsb_fs", 32'(fs_l), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("lsb_pair", 32'({d0_l, d1_l, oe_l}), 32'b001);
            check("lsb_fd", 32'(fd_l), 32'(i == 7));
        end
        tick();
        check("lsb_idle_oe", 32'(oe_l), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
